// File: rtl/axi_slave_ctrl_pkg.sv
// Shared AXI encodings for the slave controller and its memory model.
// Holds burst types, response codes and the width used for range math.
package axi_slave_ctrl_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  // Wide enough that aligned base plus burst length never wraps.
  localparam int unsigned CHK_W = 41;

endpackage

// File: rtl/axi_burst_check.sv
// Combinational legality/range check for one AXI address phase.
// Ports: addr_i, len_i, size_i, burst_i in; err_o high if illegal.
module axi_burst_check
  import axi_slave_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic        err_o
);

  localparam logic [2:0] MAX_SIZE =
    3'($clog2(DATA_WIDTH / 8));
  localparam logic [CHK_W-1:0] SPACE =
    CHK_W'(1) << ADDR_WIDTH;

  logic [CHK_W-1:0] mask;
  logic [CHK_W-1:0] base;
  logic [CHK_W-1:0] bytes;
  logic [CHK_W-1:0] last_end;
  logic             size_err;
  logic             burst_err;
  logic             range_err;

  always_comb begin
    mask      = (CHK_W'(1) << size_i) - CHK_W'(1);
    base      = CHK_W'(addr_i) & ~mask;
    bytes     = (CHK_W'(len_i) + CHK_W'(1)) << size_i;
    last_end  = base + bytes;
    size_err  = size_i > MAX_SIZE;
    burst_err = (burst_i == BURST_WRAP) ||
                (burst_i == 2'd3);
    if (burst_i == BURST_FIXED)
      range_err = CHK_W'(addr_i) >= SPACE;
    else
      range_err = last_end > SPACE;
    err_o = size_err | burst_err | range_err;
  end

endmodule

// File: rtl/axi_slave_ctrl.sv
// AXI slave control: independent write (AW/W/B) and read (AR/R) FSMs.
// Ports: AW/W/B and AR/R handshakes; all outputs registered.
module axi_slave_ctrl
  import axi_slave_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aw_addr,
  input  logic [7:0]  aw_len,
  input  logic [2:0]  aw_size,
  input  logic [1:0]  aw_burst,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic        w_last,
  input  logic        w_valid,
  output logic        w_ready,
  output logic        b_valid,
  output logic [1:0]  b_resp,
  input  logic        b_ready,
  input  logic [31:0] ar_addr,
  input  logic [7:0]  ar_len,
  input  logic [2:0]  ar_size,
  input  logic [1:0]  ar_burst,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic        r_valid,
  output logic        r_last,
  output logic [1:0]  r_resp,
  input  logic        r_ready
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic       aw_err, ar_err;

  logic [1:0] ws_q, ws_d;
  logic       aw_ready_q, aw_ready_d;
  logic       w_ready_q, w_ready_d;
  logic       b_valid_q, b_valid_d;
  logic [1:0] b_resp_q, b_resp_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] wlen_q, wlen_d;
  logic       werr_q, werr_d;

  logic [0:0] rs_q, rs_d;
  logic       ar_ready_q, ar_ready_d;
  logic       r_valid_q, r_valid_d;
  logic       r_last_q, r_last_d;
  logic [1:0] r_resp_q, r_resp_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [7:0] rlen_q, rlen_d;

  axi_burst_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_aw_chk (
    .addr_i  (aw_addr),
    .len_i   (aw_len),
    .size_i  (aw_size),
    .burst_i (aw_burst),
    .err_o   (aw_err)
  );

  axi_burst_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ar_chk (
    .addr_i  (ar_addr),
    .len_i   (ar_len),
    .size_i  (ar_size),
    .burst_i (ar_burst),
    .err_o   (ar_err)
  );

  // Address attributes matter only through their legality check,
  // so the check result is captured at the AW handshake.
  always_comb begin
    ws_d       = ws_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    wcnt_d     = wcnt_q;
    wlen_d     = wlen_q;
    werr_d     = werr_q;
    unique case (ws_q)
      W_IDLE: begin
        aw_ready_d = 1'b1;
        if (aw_valid && aw_ready_q) begin
          ws_d       = W_DATA;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          wlen_d     = aw_len;
          wcnt_d     = 8'd0;
          werr_d     = aw_err;
        end
      end
      W_DATA: begin
        if (w_valid && w_ready_q) begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) begin
            ws_d      = W_RESP;
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            werr_d    = werr_q | ~w_last;
            b_resp_d  = (werr_q | ~w_last) ?
                        RESP_SLVERR : RESP_OKAY;
          end else begin
            werr_d = werr_q | w_last;
          end
        end
      end
      W_RESP: begin
        if (b_ready) begin
          ws_d       = W_IDLE;
          b_valid_d  = 1'b0;
          b_resp_d   = RESP_OKAY;
          aw_ready_d = 1'b1;
        end
      end
      default: ws_d = W_IDLE;
    endcase
  end

  always_comb begin
    rs_d       = rs_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_last_d   = r_last_q;
    r_resp_d   = r_resp_q;
    rcnt_d     = rcnt_q;
    rlen_d     = rlen_q;
    unique case (rs_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (ar_valid && ar_ready_q) begin
          rs_d       = R_DATA;
          ar_ready_d = 1'b0;
          r_valid_d  = 1'b1;
          r_last_d   = (ar_len == 8'd0);
          r_resp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
          rlen_d     = ar_len;
          rcnt_d     = 8'd0;
        end
      end
      R_DATA: begin
        if (r_ready && r_valid_q) begin
          if (r_last_q) begin
            rs_d       = R_IDLE;
            r_valid_d  = 1'b0;
            r_last_d   = 1'b0;
            r_resp_d   = RESP_OKAY;
            ar_ready_d = 1'b1;
          end else begin
            rcnt_d   = rcnt_q + 8'd1;
            r_last_d = (rcnt_q + 8'd1) == rlen_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_q       <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      wcnt_q     <= 8'd0;
      wlen_q     <= 8'd0;
      werr_q     <= 1'b0;
      rs_q       <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      rcnt_q     <= 8'd0;
      rlen_q     <= 8'd0;
    end else begin
      ws_q       <= ws_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      wcnt_q     <= wcnt_d;
      wlen_q     <= wlen_d;
      werr_q     <= werr_d;
      rs_q       <= rs_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_resp_q   <= r_resp_d;
      rcnt_q     <= rcnt_d;
      rlen_q     <= rlen_d;
    end
  end

  assign aw_ready = aw_ready_q;
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign b_resp   = b_resp_q;
  assign ar_ready = ar_ready_q;
  assign r_valid  = r_valid_q;
  assign r_last   = r_last_q;
  assign r_resp   = r_resp_q;

endmodule

// File: tb/tb_axi_slave_ctrl.sv
// Directed bench for axi_slave_ctrl: cycle vector table plus
// hand-written multi-cycle sequences.
module tb_axi_slave_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic        w_last = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic        b_ready = 1'b0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic        r_valid;
  logic        r_last;
  logic [1:0]  r_resp;
  logic        r_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  axi_slave_ctrl #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .aw_addr  (aw_addr),
    .aw_len   (aw_len),
    .aw_size  (aw_size),
    .aw_burst (aw_burst),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .w_last   (w_last),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .b_valid  (b_valid),
    .b_resp   (b_resp),
    .b_ready  (b_ready),
    .ar_addr  (ar_addr),
    .ar_len   (ar_len),
    .ar_size  (ar_size),
    .ar_burst (ar_burst),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .r_valid  (r_valid),
    .r_last   (r_last),
    .r_resp   (r_resp),
    .r_ready  (r_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        awv;
    logic [31:0] awa;
    logic [7:0]  awl;
    logic [2:0]  aws;
    logic [1:0]  awb;
    logic        wv;
    logic        wl;
    logic        br;
    logic        arv;
    logic [31:0] ara;
    logic [7:0]  arl;
    logic [2:0]  ars;
    logic [1:0]  arb;
    logic        rr;
    logic [9:0]  exp;
  } vec_t;

  // exp = {aw_ready,w_ready,b_valid,b_resp,ar_ready,r_valid,r_last,r_resp}
  localparam logic [9:0] IDL = 10'b1_0_0_00_1_0_0_00;
  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rst, input logic awv, input logic [31:0] awa,
    input logic [7:0] awl, input logic [2:0] aws,
    input logic [1:0] awb, input logic wv, input logic wl,
    input logic br, input logic arv, input logic [31:0] ara,
    input logic [7:0] arl, input logic [2:0] ars,
    input logic [1:0] arb, input logic rr, input logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.awv = awv; v.awa = awa; v.awl = awl;
    v.aws = aws; v.awb = awb; v.wv = wv; v.wl = wl; v.br = br;
    v.arv = arv; v.ara = ara; v.arl = arl; v.ars = ars;
    v.arb = arb; v.rr = rr; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic clr_in();
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {aw_ready, w_ready, b_valid, b_resp,
            ar_ready, r_valid, r_last, r_resp};
  endfunction

  int acc;
  int hs;
  int beat;
  logic ev;
  logic [4:0] pat;

  initial begin
    tbl[0]  = mk(1,0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0, 10'b0);
    tbl[1]  = mk(1,0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0, 10'b0);
    tbl[2]  = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0, IDL);
    tbl[3]  = mk(0,1,32'h10,3,2,1, 0,0,1, 0,0,0,0,0, 0,
                 10'b0_1_0_00_1_0_0_00);
    tbl[4]  = mk(0,0,0,0,0,0, 1,0,1, 0,0,0,0,0, 0,
                 10'b0_1_0_00_1_0_0_00);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(0,0,0,0,0,0, 1,1,1, 0,0,0,0,0, 0,
                 10'b0_0_1_00_1_0_0_00);
    tbl[8]  = mk(0,0,0,0,0,0, 0,0,1, 0,0,0,0,0, 0, IDL);
    tbl[9]  = mk(0,1,0,0,2,1, 0,0,0, 1,32'h20,1,2,1, 0,
                 10'b0_1_0_00_0_1_0_00);
    tbl[10] = mk(0,0,0,0,0,0, 1,1,0, 0,0,0,0,0, 1,
                 10'b0_0_1_00_0_1_1_00);
    tbl[11] = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,
                 10'b0_0_1_00_0_1_1_00);
    tbl[12] = mk(0,0,0,0,0,0, 0,0,1, 0,0,0,0,0, 1, IDL);
    tbl[13] = mk(0,1,0,0,3,1, 0,0,0, 0,0,0,0,0, 0,
                 10'b0_1_0_00_1_0_0_00);
    tbl[14] = mk(0,0,0,0,0,0, 1,1,0, 0,0,0,0,0, 0,
                 10'b0_0_1_10_1_0_0_00);
    tbl[15] = mk(0,0,0,0,0,0, 0,0,1, 0,0,0,0,0, 0, IDL);
    tbl[16] = mk(0,0,0,0,0,0, 0,0,0, 1,0,0,2,2, 0,
                 10'b1_0_0_00_0_1_1_10);
    tbl[17] = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,0, 1, IDL);
    tbl[18] = mk(0,0,0,0,0,0, 0,0,0, 1,32'h100,0,0,0, 0,
                 10'b1_0_0_00_0_1_1_10);
    tbl[19] = tbl[17];
    tbl[20] = mk(0,0,0,0,0,0, 0,0,0, 1,32'hFC,0,2,1, 0,
                 10'b1_0_0_00_0_1_1_00);
    tbl[21] = tbl[17];
    tbl[22] = mk(0,0,0,0,0,0, 0,0,0, 1,32'hFE,0,2,1, 0,
                 10'b1_0_0_00_0_1_1_00);
    tbl[23] = tbl[17];
    tbl[24] = mk(0,1,0,0,2,3, 0,0,0, 0,0,0,0,0, 0,
                 10'b0_1_0_00_1_0_0_00);
    tbl[25] = mk(0,0,0,0,0,0, 1,1,0, 0,0,0,0,0, 0,
                 10'b0_0_1_10_1_0_0_00);
    tbl[26] = mk(0,0,0,0,0,0, 0,0,1, 0,0,0,0,0, 0, IDL);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      aw_valid = tbl[i].awv; aw_addr = tbl[i].awa;
      aw_len = tbl[i].awl; aw_size = tbl[i].aws;
      aw_burst = tbl[i].awb;
      w_valid = tbl[i].wv; w_last = tbl[i].wl;
      b_ready = tbl[i].br;
      ar_valid = tbl[i].arv; ar_addr = tbl[i].ara;
      ar_len = tbl[i].arl; ar_size = tbl[i].ars;
      ar_burst = tbl[i].arb;
      r_ready = tbl[i].rr;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // 8-beat read crossing the top of memory: all SLVERR.
    @(negedge clk);
    clr_in();
    ar_valid = 1'b1; ar_addr = 32'hF0; ar_len = 8'd7;
    ar_size = 3'd2; ar_burst = 2'd1; r_ready = 1'b1;
    step();
    ar_valid = 1'b0;
    chk("rd8_arrdy", 32'(ar_ready), 32'd0);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("rd8_v%0d", b), 32'(r_valid), 32'd1);
      chk($sformatf("rd8_l%0d", b), 32'(r_last), 32'(b == 7));
      chk($sformatf("rd8_r%0d", b), 32'(r_resp), 32'd2);
      step();
    end
    chk("rd8_end_v", 32'(r_valid), 32'd0);
    chk("rd8_end_ar", 32'(ar_ready), 32'd1);

    // len 1 write with w_last on the first beat.
    clr_in();
    acc = 0;
    aw_valid = 1'b1; aw_addr = 32'h0; aw_len = 8'd1;
    aw_size = 3'd2; aw_burst = 2'd1;
    step();
    aw_valid = 1'b0;
    w_valid = 1'b1; w_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (w_valid && w_ready) acc++;
      step();
      w_last = 1'b0;
    end
    chk("wl1_acc", 32'(acc), 32'd2);
    chk("wl1_wrdy", 32'(w_ready), 32'd0);
    chk("wl1_bv", 32'(b_valid), 32'd1);
    chk("wl1_resp", 32'(b_resp), 32'd2);
    w_valid = 1'b0; b_ready = 1'b1;
    step();
    chk("wl1_bdone", 32'(b_valid), 32'd0);
    chk("wl1_awrdy", 32'(aw_ready), 32'd1);

    // len 2 read with r_ready stalls.
    clr_in();
    ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd2;
    ar_size = 3'd2; ar_burst = 2'd1;
    step();
    ar_valid = 1'b0;
    pat = 5'b10101;
    beat = 0; ev = 1'b1; hs = 0;
    for (int i = 0; i < 5; i++) begin
      r_ready = pat[i];
      if (r_ready && ev) beat++;
      if (r_ready && r_valid) hs++;
      step();
      ev = beat < 3;
      chk($sformatf("stall_v%0d", i), 32'(r_valid), 32'(ev));
      chk($sformatf("stall_l%0d", i), 32'(r_last),
          32'(beat == 2));
    end
    chk("stall_hs", 32'(hs), 32'd3);
    chk("stall_arrdy", 32'(ar_ready), 32'd1);

    // Reset during beat 2 of a len 3 write.
    clr_in();
    aw_valid = 1'b1; aw_addr = 32'h0; aw_len = 8'd3;
    aw_size = 3'd2; aw_burst = 2'd1;
    step();
    aw_valid = 1'b0; w_valid = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("rst_mid0", 32'(outs()), 32'd0);
    step();
    chk("rst_mid1", 32'(outs()), 32'd0);
    reset = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    step();
    chk("rst_awrdy", 32'(aw_ready), 32'd1);
    chk("rst_arrdy", 32'(ar_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_nob%0d", c), 32'(b_valid), 32'd0);
      chk($sformatf("rst_now%0d", c), 32'(w_ready), 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_slave_ctrl.md
AXI_SLAVE_CTRL -- requirements
Module: axi_slave_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: byte-address space of the attached memory (2**ADDR_WIDTH bytes).
REQ-002 Parameter DATA_WIDTH, default 32: data bus width in bits; the maximum legal size is log2(DATA_WIDTH/8).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 aw_addr  in  32  write start address.
REQ-006 aw_len  in  8  write beats minus 1.
REQ-007 aw_size  in  3  log2 bytes per write beat.
REQ-008 aw_burst  in  2  write burst type.
REQ-009 aw_valid in 1 / aw_ready out 1  AW handshake.
REQ-010 w_last in 1, w_valid in 1 / w_ready out 1  W handshake plus last-beat flag.
REQ-011 b_valid out 1, b_resp out 2 / b_ready in 1  write response.
REQ-012 ar_addr in 32, ar_len in 8, ar_size in 3, ar_burst in 2  read address attributes.
REQ-013 ar_valid in 1 / ar_ready out 1  AR handshake.
REQ-014 r_valid out 1, r_last out 1, r_resp out 2 / r_ready in 1  read beat control.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP; read FSM states SHALL be R_IDLE, R_DATA; the two FSMs SHALL be fully independent and may run concurrently.
REQ-017 W_IDLE: aw_ready=1; on aw_valid&aw_ready in cycle N, the block SHALL latch len, size, burst and address, drop aw_ready and raise w_ready in cycle N+1 (W_DATA).
REQ-018 W_DATA: each w_valid&w_ready cycle SHALL increment an 8-bit beat counter; w_ready SHALL stay 1 back-to-back.
REQ-019 On the beat where count==len, w_ready SHALL drop next cycle and b_valid SHALL rise (W_RESP); beats are never accepted beyond len+1.
REQ-020 Error flag (write) SHALL be set if: w_last=1 on a beat with count!=len; w_last=0 on the final beat; aw_size>log2(DATA_WIDTH/8); aw_burst==WRAP or reserved(3); aligned start address + (len+1)*2**size > 2**ADDR_WIDTH for INCR (or start address >= 2**ADDR_WIDTH for FIXED).
REQ-021 b_resp SHALL be SLVERR if the error flag is set, else OKAY; b_valid and b_resp SHALL hold stable until b_ready; on b_valid&b_ready the FSM SHALL return to W_IDLE with aw_ready=1 in the next cycle.
REQ-022 R_IDLE: ar_ready=1; on ar_valid&ar_ready in cycle N, r_valid SHALL rise in cycle N+1 (R_DATA) and ar_ready SHALL drop.
REQ-023 R_DATA: r_valid, r_last and r_resp SHALL hold stable while r_ready=0; each r_valid&r_ready SHALL advance the beat counter; r_last=1 exactly when count==ar_len.
REQ-024 Read error checks SHALL be the same as REQ-020 (size, burst, range); all read beats SHALL carry r_resp=SLVERR if any check fails, else OKAY; the full len+1 beats SHALL still be issued.
REQ-025 After the r_last handshake, the FSM SHALL return to R_IDLE (r_valid=0, ar_ready=1 in the next cycle).
REQ-026 aw_len=0 or ar_len=0 SHALL produce a single-beat burst whose only beat is last.
REQ-027 The unaligned start address SHALL be aligned down to 2**size before the range check.
REQ-028 Address arithmetic SHALL use at least 41 bits so no check wraps.

Reset
REQ-029 While reset=1, every output SHALL be 0, both FSMs SHALL be in IDLE, and the counters and error flags SHALL clear; this SHALL also apply mid-burst, and any partial burst is abandoned.
REQ-030 aw_ready and ar_ready SHALL first be 1 in the cycle after reset deasserts.

Structure
REQ-031 A shared package SHALL hold the burst encodings FIXED=0, INCR=1, WRAP=2 and the response codes OKAY=0, SLVERR=2; the block and the memory model SHALL both use these.
REQ-032 The legality/range checker SHALL be one combinational sub-module, axi_burst_check, instantiated once for AW and once for AR.

Verification
REQ-033 AW INCR addr 0x10, len 3, size 2, 4 W beats with w_last on beat 4, b_ready=1 -> w_ready high 4 cycles, b_valid the next cycle, b_resp=OKAY.
REQ-034 AR addr 0xF0, len 7, size 2, INCR -> 8 beats, r_last on beat 8 only, r_resp=SLVERR on all beats (0xF0+32 > 256).
REQ-035 Write len 1 with w_last on beat 1 -> 2 beats accepted, b_resp=SLVERR.
REQ-036 Read len 2 with r_ready toggling 1,0,1,0,1 -> r_valid/r_last stable during stalls, exactly 3 handshakes, then ar_ready=1.
REQ-037 Concurrent AW and AR in the same cycle -> both FSMs progress independently, and both responses are OKAY.
REQ-038 reset pulsed during W_DATA beat 2 of len 3 -> all outputs 0, then aw_ready=1 in the cycle after release, and no b_valid for the abandoned burst.
